// File: rtl/latch_dump_ctrl.sv
// Walks the fixed pipeline-latch select table, captures each 32-bit read-back word
// and streams it as four bytes toward a UART transmitter with valid/ready handshake.
module latch_dump_ctrl #(
    parameter bit MSB_FIRST   = 1'b1,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    output logic [6:0]  o_mux_sel,
    input  logic [31:0] i_mux_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT,
        CAPTURE,
        SEND,
        NEXT,
        DONE
    } DumpState;

    localparam logic [4:0] LAST_INDEX = 5'd18;
    localparam logic [2:0] LAST_WAIT  = 3'(WAIT_CYCLES - 1);

    DumpState    state;
    logic [4:0]  index;
    logic [2:0]  waitCnt;
    logic [1:0]  byteCnt;
    logic [31:0] shiftReg;
    logic [6:0]  muxSel;
    logic        txValid;
    logic        busy;
    logic        done;

    function automatic logic [6:0] codeAt(input logic [4:0] idx);
        logic [6:0] code;
        code = 7'h00;
        case (idx)
            5'd0:    code = 7'h00;
            5'd1:    code = 7'h01;
            5'd2:    code = 7'h10;
            5'd3:    code = 7'h11;
            5'd4:    code = 7'h12;
            5'd5:    code = 7'h13;
            5'd6:    code = 7'h14;
            5'd7:    code = 7'h15;
            5'd8:    code = 7'h20;
            5'd9:    code = 7'h21;
            5'd10:   code = 7'h23;
            5'd11:   code = 7'h24;
            5'd12:   code = 7'h25;
            5'd13:   code = 7'h30;
            5'd14:   code = 7'h31;
            5'd15:   code = 7'h32;
            5'd16:   code = 7'h33;
            5'd17:   code = 7'h40;
            5'd18:   code = 7'h41;
            default: code = 7'h00;
        endcase
        return code;
    endfunction

    // The outgoing byte always sits at the leading end of the shift register,
    // so holding the register during a stall holds the byte as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            index    <= 5'd0;
            waitCnt  <= 3'd0;
            byteCnt  <= 2'd0;
            shiftReg <= 32'd0;
            muxSel   <= 7'h00;
            txValid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        index <= 5'd0;
                        busy  <= 1'b1;
                        state <= SEL;
                    end
                end
                SEL: begin
                    muxSel  <= codeAt(index);
                    waitCnt <= 3'd0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (waitCnt == LAST_WAIT) begin
                        state <= CAPTURE;
                    end else begin
                        waitCnt <= waitCnt + 3'd1;
                    end
                end
                CAPTURE: begin
                    shiftReg <= i_mux_data;
                    byteCnt  <= 2'd0;
                    txValid  <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (i_tx_ready) begin
                        shiftReg <= MSB_FIRST ? {shiftReg[23:0], 8'h00} : {8'h00, shiftReg[31:8]};
                        byteCnt  <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            txValid <= 1'b0;
                            state   <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    if (index == LAST_INDEX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        index <= index + 5'd1;
                        state <= SEL;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_mux_sel  = muxSel;
    assign o_tx_data  = MSB_FIRST ? shiftReg[31:24] : shiftReg[7:0];
    assign o_tx_valid = txValid;
    assign o_busy     = busy;
    assign o_done     = done;

endmodule

// File: doc/latch_dump_ctrl.md
LATCH_DUMP_CTRL -- requirements
Module: latch_dump_ctrl

Interface
REQ-001 Parameter: MSB_FIRST, default 1, byte order of each 32-bit word on the byte stream (1 = bits 31:24 first, 0 = bits 7:0 first).
REQ-002 Parameter: WAIT_CYCLES, default 1, clocks between a select change and the capture of i_mux_data (range 1..7).
REQ-003 Port: clk, input, 1, single clock; all state updates on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-low reset.
REQ-005 Port: i_start, input, 1, request a full latch dump; sampled only in IDLE.
REQ-006 Port: o_mux_sel, output, 7, latch-select code driven to the pipeline latch mux.
REQ-007 Port: i_mux_data, input, 32, registered mux read-back word.
REQ-008 Port: o_tx_data, output, 8, byte toward UART transmitter.
REQ-009 Port: o_tx_valid, output, 1, o_tx_data holds a byte to transfer.
REQ-010 Port: i_tx_ready, input, 1, transmitter accepts a byte this cycle.
REQ-011 Port: o_busy, output, 1, high in every state except IDLE.
REQ-012 Port: o_done, output, 1, one-cycle pulse after the last byte of a dump transfers.

Function
REQ-013 The block SHALL hold a fixed ordered table of 19 codes: 0x00,0x01,0x10,0x11,0x12,0x13,0x14,0x15,0x20,0x21,0x23,0x24,0x25,0x30,0x31,0x32,0x33,0x40,0x41 (index 0..18).
REQ-014 The FSM SHALL have states IDLE, SEL, WAIT, CAPTURE, SEND, NEXT, DONE.
REQ-015 IDLE: i_start=1 at an edge SHALL load index=0 and go to SEL; i_start outside IDLE SHALL be ignored.
REQ-016 SEL: o_mux_sel SHALL take table[index] and the FSM SHALL go to WAIT.
REQ-017 WAIT: the FSM SHALL stay exactly WAIT_CYCLES clocks (counter), then go to CAPTURE.
REQ-018 o_mux_sel SHALL stay constant from SEL until the NEXT state of the same word.
REQ-019 CAPTURE: i_mux_data SHALL be loaded into a 32-bit shift register, byte counter cleared to 0, FSM to SEND.
REQ-020 SEND: o_tx_valid=1 and o_tx_data=current byte per MSB_FIRST; data SHALL not change while valid=1 and ready=0.
REQ-021 A byte SHALL transfer on an edge where o_tx_valid=1 and i_tx_ready=1; the block SHALL shift to the next byte and increment the byte counter.
REQ-022 o_tx_valid SHALL stay high between bytes of one word (back-to-back throughput of 1 byte/clock with ready held high).
REQ-023 After the 4th byte transfers, the FSM SHALL go to NEXT with o_tx_valid=0.
REQ-024 NEXT: index=18 SHALL go to DONE; otherwise index increments by 1 and the FSM goes to SEL.
REQ-025 DONE: o_done=1 for exactly one clock, then the FSM goes to IDLE.
REQ-026 A dump SHALL emit exactly 76 bytes, in table order.
REQ-027 i_tx_ready held low SHALL stall indefinitely in SEND with no byte loss or duplication.
REQ-028 i_start asserted in the DONE cycle SHALL be ignored; i_start in the following IDLE cycle SHALL start a new dump.

Reset
REQ-029 rst=0 SHALL immediately, without a clock, force state=IDLE, index=0, byte counter=0, shift register=0, o_mux_sel=0x00, o_tx_data=0x00, o_tx_valid=0, o_busy=0, o_done=0.
REQ-030 Reset asserted mid-dump SHALL abort the dump and emit no further bytes; after release, the block SHALL wait for a new i_start.
REQ-031 The first i_start edge after reset release SHALL be honoured.

Verification
REQ-032 Scenario: start with ready=1, model mux returns {code,code,code,code} per select -> 76 bytes; byte 0..3 = 0x00, bytes 40..43 = 0x23, last 4 = 0x41; o_done pulses once.
REQ-033 Scenario: MSB_FIRST=1, data for code 0x01 = 0xDEADBEEF -> bytes DE,AD,BE,EF; MSB_FIRST=0 -> EF,BE,AD,DE.
REQ-034 Scenario: ready toggles 0/1 randomly -> identical byte sequence to REQ-032; o_tx_data stable while valid&&!ready.
REQ-035 Scenario: i_start pulsed during word index 5 -> ignored; total still 76 bytes, one o_done.
REQ-036 Scenario: rst=0 after 10 transferred bytes -> o_tx_valid=0 and o_busy=0 asynchronously, o_mux_sel=0x00; no bytes until next i_start, then the dump restarts at code 0x00.
REQ-037 Scenario: WAIT_CYCLES=3 and the mux model delays data 3 clocks after the select change -> captured words correct; o_mux_sel constant for every word.
